// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data memory initiator (mem_access_ctrl).
// Holds the FSM state encoding and the default highest legal word address.
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_SIZE = 255;

    typedef enum logic [1:0] {
        MAC_IDLE   = 2'd0,
        MAC_ACCESS = 2'd1,
        MAC_RESP   = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data memory port: one load/store in flight, in-order responses.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (suppresses out-of-range accesses, flags resp_err).
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 16,
    parameter int unsigned MEM_LAST = DATA_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [1:0]        fsm_state
);

    // Handshake: a request transfers on the posedge where req_valid && req_ready;
    // a response transfers on the posedge where resp_valid && resp_ready.

    mac_state_e        state_q;
    mac_state_e        next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              oob;
    logic              accept;

`ifdef MEM_BOUNDS_CHECK_EN
    assign oob = (32'(addr_q) > MEM_LAST);
`else
    logic unused_mem_last;
    assign unused_mem_last = ^MEM_LAST;
    assign oob = 1'b0;
`endif

    assign accept         = req_valid && req_ready;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;
    assign fsm_state      = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MAC_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            MAC_IDLE:   if (accept) next_state = MAC_ACCESS;
            MAC_ACCESS: next_state = MAC_RESP;
            MAC_RESP: begin
                if (resp_ready) begin
                    next_state = accept ? MAC_ACCESS : MAC_IDLE;
                end
            end
            default:    next_state = MAC_IDLE;
        endcase
    end

    // Strobes are decoded from the state register so reset drops them immediately.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state_q)
            MAC_IDLE:   req_ready = 1'b1;
            MAC_ACCESS: begin
                mem_write = write_q && !oob;
                mem_read  = !write_q && !oob;
            end
            MAC_RESP: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
            end
            if (state_q == MAC_ACCESS) begin
                rdata_q <= (write_q || oob) ? '0 : mem_read_data;
                err_q   <= oob;
            end else if (state_q == MAC_RESP && resp_ready) begin
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a negedge-write / combinational-read memory.
// Expected responses come from a transaction-level shadow memory and an expected queue.
module tb_mem_access_ctrl;

    localparam int          DATA_W   = 16;
    localparam int          ADDR_W   = 16;
    localparam int unsigned MEM_LAST = 255;
`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;
    logic [1:0]        fsm_state;

    logic [DATA_W-1:0] mem     [0:65535];
    logic [DATA_W-1:0] ref_mem [0:65535];
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_err_q[$];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    mem_access_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_LAST (MEM_LAST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, write commits on the falling edge.
    assign mem_read_data = mem[mem_address];

    always @(negedge clk) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write) wr_cnt++;
        if (mem_read) rd_cnt++;
        if (mem_write || mem_read) check("strobe_exclusive", {31'd0, mem_write && mem_read}, 32'd0);
    end

    function automatic bit is_oob(input logic [ADDR_W-1:0] a);
        return CHK_EN && (32'(a) > MEM_LAST);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, {16'd0, resp_rdata}, 32'd0);
        check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        check({tag, "_mem_address"}, {16'd0, mem_address}, 32'd0);
        check({tag, "_mem_wdata"}, {16'd0, mem_write_data}, 32'd0);
        check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
        check({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    endtask

    // One complete transaction from IDLE; junk drives req_* while the controller is busy.
    task automatic transact(input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int hold, input bit junk);
        bit                oob;
        bit                acc;
        int                wr0;
        int                rd0;
        logic [DATA_W-1:0] first;
        logic [DATA_W-1:0] exp_r;
        logic              exp_e;
        oob = is_oob(a);
        if (w) begin
            if (!oob) ref_mem[a] = d;
            exp_q.push_back('0);
        end else begin
            exp_q.push_back(oob ? '0 : ref_mem[a]);
        end
        exp_err_q.push_back(oob);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = req_ready;
            @(posedge clk); #1;
        end
        check("accept", {31'd0, acc}, 32'd1);
        if (junk) begin
            req_write = ~w;
            req_addr  = a ^ 16'h0005;
            req_wdata = 16'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        check("acc_addr", {16'd0, mem_address}, {16'd0, a});
        check("acc_mem_write", {31'd0, mem_write}, {31'd0, w && !oob});
        check("acc_mem_read", {31'd0, mem_read}, {31'd0, !w && !oob});
        check("acc_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("acc_req_ready", {31'd0, req_ready}, 32'd0);
        if (w && !oob) check("acc_wdata", {16'd0, mem_write_data}, {16'd0, d});
        @(posedge clk); #1;
        check("resp_valid_rise", {31'd0, resp_valid}, 32'd1);
        first = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", {16'd0, resp_rdata}, {16'd0, first});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        exp_r = exp_q.pop_front();
        exp_e = exp_err_q.pop_front();
        check("resp_rdata", {16'd0, resp_rdata}, {16'd0, exp_r});
        check("resp_err", {31'd0, resp_err}, {31'd0, exp_e});
        resp_ready = 1'b1;
        #1;
        check("resp_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("consumed_valid", {31'd0, resp_valid}, 32'd0);
        check("consumed_err", {31'd0, resp_err}, 32'd0);
        check("wr_strobes", wr_cnt - wr0, {31'd0, w && !oob});
        check("rd_strobes", rd_cnt - rd0, {31'd0, !w && !oob});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] old_v;
        logic [ADDR_W-1:0] ra;
        int                wr0;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset state
        #1;
        check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("post_reset");

        // Store then load back
        transact(1'b1, 16'h0004, 16'hBEEF, 0, 1'b0);
        transact(1'b0, 16'h0004, 16'h0000, 0, 1'b0);

        // Back-to-back loads with resp_ready held high
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 16'h0001;
        @(posedge clk); #1;
        check("b2b_acc1_read", {31'd0, mem_read}, 32'd1);
        check("b2b_acc1_addr", {16'd0, mem_address}, 32'd1);
        req_addr = 16'h0002;
        @(posedge clk); #1;
        check("b2b_resp1_valid", {31'd0, resp_valid}, 32'd1);
        check("b2b_resp1_rdata", {16'd0, resp_rdata}, {16'd0, ref_mem[1]});
        check("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_acc2_read", {31'd0, mem_read}, 32'd1);
        check("b2b_acc2_addr", {16'd0, mem_address}, 32'd2);
        check("b2b_acc2_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("b2b_resp2_valid", {31'd0, resp_valid}, 32'd1);
        check("b2b_resp2_rdata", {16'd0, resp_rdata}, {16'd0, ref_mem[2]});
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("b2b_idle_valid", {31'd0, resp_valid}, 32'd0);
        check("b2b_idle_ready", {31'd0, req_ready}, 32'd1);

        // Response stalled for 5 cycles
        transact(1'b0, 16'h0003, 16'h0000, 5, 1'b1);

        // Reset during the access cycle of a store, before the committing negedge
        old_v = ref_mem[16'h0010];
        wr0   = wr_cnt;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0010;
        req_wdata = 16'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_pre_mem_write", {31'd0, mem_write}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk); #1;
        check("rst_mem_kept", {16'd0, mem[16'h0010]}, {16'd0, old_v});
        check("rst_no_commit", wr_cnt - wr0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_after");

        // Boundary addresses
        transact(1'b1, 16'(MEM_LAST + 1), 16'hA5A5, 1, 1'b0);
        transact(1'b0, 16'(MEM_LAST + 1), 16'h0000, 0, 1'b0);
        transact(1'b1, 16'(MEM_LAST), 16'h5A5A, 0, 1'b0);
        transact(1'b0, 16'(MEM_LAST), 16'h0000, 2, 1'b0);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       ra = 16'(MEM_LAST);
                1:       ra = 16'(MEM_LAST + 1);
                2:       ra = 16'(MEM_LAST + $urandom_range(2, 9));
                default: ra = 16'($urandom_range(0, 15));
            endcase
            transact(1'($urandom_range(0, 1)), ra, 16'($urandom), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
        end

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
